// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding and frame constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } ps2_state_e;

    localparam int FILTER_LEN_DEF = 8;
    localparam int DATA_BITS      = 8;
    localparam int SHIFT_CNT      = 9;

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter on the sampled PS/2 clock plus a one-cycle falling-edge pulse.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic reloj,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filt_q;
    logic [FILTER_LEN-1:0] filt_d;
    logic                  f_q;
    logic                  f_d;

    assign filt_d = {ps2c_in, filt_q[FILTER_LEN-1:1]};

    // Mixed history keeps the previous level.
    always_comb begin
        f_d = f_q;
        if (&filt_q) begin
            f_d = 1'b1;
        end else if (~|filt_q) begin
            f_d = 1'b0;
        end
    end

    assign fall_edge = f_q & ~f_d;

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            filt_q <= '1;
            f_q    <= 1'b1;
        end else begin
            filt_q <= filt_d;
            f_q    <= f_d;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-collector drive/enable outputs).
// Optional device watchdog enabled with `define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_out,
    output logic       ps2d_out,
    output logic       tri_c,
    output logic       tri_d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif

    ps2_state_e           state_q;
    logic [SHIFT_CNT-1:0] b_q;
    logic [3:0]           n_q;
    logic [CW-1:0]        c_q;
    logic                 tri_c_q;
    logic                 tri_d_q;
    logic                 d_out_q;
    logic                 done_q;
    logic                 err_q;
    logic                 idle_q;
    logic                 fall_edge;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .reloj     (reloj),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            n_q     <= '0;
            c_q     <= '0;
            tri_c_q <= 1'b0;
            tri_d_q <= 1'b0;
            d_out_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (wr_ps2) begin
                        b_q     <= {~^din, din};
                        c_q     <= '0;
                        err_q   <= 1'b0;
                        idle_q  <= 1'b0;
                        tri_c_q <= 1'b1;
                        state_q <= S_RTS;
                    end
                end
                S_RTS: begin
                    if (c_q == INH_LAST) begin
                        tri_c_q <= 1'b0;
                        tri_d_q <= 1'b1;
                        d_out_q <= 1'b0;
                        c_q     <= '0;
                        state_q <= S_START;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                S_START: begin
                    if (fall_edge) begin
                        d_out_q <= b_q[0];
                        n_q     <= 4'(DATA_BITS);
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (fall_edge) begin
                        if (n_q == 4'd0) begin
                            tri_d_q <= 1'b0;
                            d_out_q <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            b_q     <= b_q >> 1;
                            d_out_q <= b_q[1];
                            n_q     <= n_q - 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (fall_edge) begin
                        err_q   <= ps2d_in;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides the case above when the device goes silent.
            if (state_q inside {S_START, S_DATA, S_STOP}) begin
                if (fall_edge) begin
                    c_q <= '0;
                end else if (c_q == TO_LAST) begin
                    tri_c_q <= 1'b0;
                    tri_d_q <= 1'b0;
                    d_out_q <= 1'b1;
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
`endif
        end
    end

    assign ps2c_out     = 1'b0;
    assign ps2d_out     = d_out_q;
    assign tri_c        = tri_c_q & reset;
    assign tri_d        = tri_d_q & reset;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign ack_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized frames against a wired-AND PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 300;
    localparam int HALF = 40;
    localparam int TO   = 1000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       wr       = 1'b0;
    logic [7:0] din      = 8'h00;
    logic       ps2c_dev = 1'b1;
    logic       ps2d_dev = 1'b1;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_out;
    logic       ps2d_out;
    logic       tri_c;
    logic       tri_d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    always #5 clk = ~clk;

    assign ps2c_in = (tri_c ? ps2c_out : 1'b1) & ps2c_dev;
    assign ps2d_in = (tri_d ? ps2d_out : 1'b1) & ps2d_dev;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .reloj        (clk),
        .reset        (rst_n),
        .wr_ps2       (wr),
        .din          (din),
        .ps2c_in      (ps2c_in),
        .ps2d_in      (ps2d_in),
        .ps2c_out     (ps2c_out),
        .ps2d_out     (ps2d_out),
        .tri_c        (tri_c),
        .tri_d        (tri_d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err)
    );

    always @(negedge clk) begin
        if (rst_n && tx_done_tick) dones++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 normal, 1 extra wr during data, 2 reset at bit 4, 3 clock glitch
    task automatic frame(input logic [7:0] d, input bit ack, input int mode);
        logic [10:0] got;
        logic [10:0] exp;
        logic        par;
        int          cnt;
        int          d0;
        par = ($countones(d) % 2 == 0);
        exp = {1'b1, par, d, 1'b0};
        got = '1;
        d0  = dones;
        din = d;
        wr  = 1'b1;
        tick(1);
        wr  = 1'b0;
        din = 8'($urandom);
        chk("busy", {tx_idle, tri_c}, 2'b01);
        cnt = 0;
        while (tri_c && cnt < INH + 50) begin
            tick(1);
            cnt++;
        end
        chk("inhibit", cnt, INH);
        chk("start_drv", tri_d, 1'b1);
        got[0] = ps2d_in;
        tick(20);
        for (int k = 1; k <= 10; k++) begin
            ps2c_dev = 1'b0;
            tick(HALF);
            if (mode == 2 && k == 5) begin
                #2 rst_n = 1'b0;
                #1 chk("abort_lines", {tri_c, tri_d}, 2'b00);
                ps2c_dev = 1'b1;
                tick(3);
                rst_n = 1'b1;
                tick(2);
                chk("abort_idle", {tx_idle, tx_done_tick, tri_d}, 3'b100);
                chk("abort_nodone", dones - d0, 0);
                return;
            end
            ps2c_dev = 1'b1;
            got[k] = ps2d_in;
            if (mode == 1 && k == 4) begin
                din = 8'h55;
                wr  = 1'b1;
                tick(1);
                wr  = 1'b0;
                tick(HALF - 1);
            end else if (mode == 3 && k == 5) begin
                tick(10);
                ps2c_dev = 1'b0;
                tick(2);
                ps2c_dev = 1'b1;
                tick(20);
                chk("glitch_hold", ps2d_in, got[k]);
`ifdef PS2_TX_TIMEOUT_EN
                cnt = 0;
                while (!tx_done_tick && cnt < 3 * TO) begin
                    tick(1);
                    cnt++;
                end
                chk("to_done", tx_done_tick, 1'b1);
                chk("to_err", ack_err, 1'b1);
                chk("to_lines", {tri_c, tri_d}, 2'b00);
                tick(1);
                chk("to_idle", tx_idle, 1'b1);
                return;
`endif
                tick(HALF - 32);
            end else begin
                tick(HALF);
            end
        end
        ps2d_dev = ack ? 1'b0 : 1'b1;
        tick(5);
        ps2c_dev = 1'b0;
        cnt = 0;
        while (!tx_done_tick && cnt < 4 * HALF) begin
            tick(1);
            cnt++;
        end
        chk("done_seen", tx_done_tick, 1'b1);
        chk("ack_err", ack_err, !ack);
        chk("frame", got, exp);
        tick(1);
        chk("idle_after", {tx_idle, tx_done_tick}, 2'b10);
        tick(HALF);
        ps2c_dev = 1'b1;
        ps2d_dev = 1'b1;
        tick(HALF);
        chk("ack_hold", ack_err, !ack);
        chk("one_done", dones - d0, 1);
    endtask

    initial begin
        tick(3);
        chk("rst_state",
            {tx_idle, tri_c, tri_d, ps2d_out, tx_done_tick, ack_err, ps2c_out},
            7'b1001000);
        rst_n = 1'b1;
        tick(5);
        chk("rst_release", {tx_idle, tri_c, tx_done_tick}, 3'b100);
        frame(8'hED, 1'b1, 0);
        frame(8'h01, 1'b1, 0);
        frame(8'h00, 1'b1, 0);
        frame(8'hA7, 1'b0, 0);
        frame(8'h3C, 1'b1, 1);
        frame(8'h96, 1'b1, 2);
        tick(5);
        frame(8'h5A, 1'b1, 3);
        tick(5);
        for (int i = 0; i < 5; i++) begin
            frame(8'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) from the FPGA to the keyboard.
- Uses the same ps2c/ps2d pair as the existing PS/2 receive path. Lines are open-collector: this block outputs drive-low values plus tri-state enables, and the top level builds the IOBUFs.
- tx_idle gates the receiver so it ignores bus activity caused by our own transmission.

Parameters:
- INHIBIT_CYCLES, 12000, reloj cycles the clock line is held low for request-to-send (120 us at 100 MHz; must be ≥100 us).
- FILTER_LEN, 8, glitch-filter depth on the sampled ps2c (all-ones → high, all-zeros → low).
- TIMEOUT_CYCLES, 2_000_000, watchdog limit; used only with PS2_TX_TIMEOUT_EN.

Ports:
- reloj  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- wr_ps2  in  1  one-cycle request to send din; honoured only when tx_idle=1
- din  in  8  command byte, captured on the accepted wr_ps2
- ps2c_in  in  1  sampled PS/2 clock line
- ps2d_in  in  1  sampled PS/2 data line
- ps2c_out  out  1  value driven on clock when tri_c=1 (always 0)
- ps2d_out  out  1  value driven on data when tri_d=1
- tri_c  out  1  1 = drive clock line
- tri_d  out  1  1 = drive data line
- tx_idle  out  1  1 = idle, ready to accept wr_ps2
- tx_done_tick  out  1  one-cycle pulse at end of frame
- ack_err  out  1  valid with tx_done_tick; 1 = device did not pull data low for ACK

Behaviour:
- Reset: state=idle, tri_c=0, tri_d=0, ps2d_out=1, tx_done_tick=0, ack_err=0, tx_idle=1.
  - Filter register resets to all-ones and filtered clock to 1, so no falling edge is produced at reset release.
  - Reset asserted mid-frame releases both lines combinationally and immediately.
- Clock filter: shift ps2c_in into a FILTER_LEN register.
  - fall_edge = filtered clock 1→0, exactly one reloj cycle wide.
- Shift register b[8:0] = {odd parity, din}, with parity = ~^din. Bit counter n[3:0]. Inhibit/timeout counter c, sized to fit max(INHIBIT_CYCLES, TIMEOUT_CYCLES).
- idle:
  - tx_idle=1, both lines released.
  - wr_ps2 → load b, clear c → rts.
- rts:
  - tri_c=1 (clock low).
  - When c==INHIBIT_CYCLES-1 → start; otherwise increment c.
  - fall_edge is ignored here (we are driving the clock).
- start:
  - tri_c=0, tri_d=1, ps2d_out=0 (start bit).
  - fall_edge (1st device edge) → data, n=8.
- data:
  - tri_d=1, ps2d_out=b[0].
  - On fall_edge: if n==0 → stop; else b=b>>1, n=n-1.
  - Edges 2..9 present d1..d7 and parity; edge 10 → stop.
- stop:
  - tri_d=0 (data released, stop bit = 1).
  - fall_edge (11th) → capture ack_err=ps2d_in → done.
- done:
  - tx_done_tick=1 for one cycle → idle.
  - ack_err holds its value until the next accepted wr_ps2.
- wr_ps2 while tx_idle=0 is ignored; din changes after acceptance have no effect.
- tx_idle=0 in every state except idle.
- Latency from wr_ps2 to the clock line being released: exactly INHIBIT_CYCLES+1 cycles.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- Defined:
  - c restarts at 0 on entry to start and on every fall_edge in start/data/stop.
  - If c reaches TIMEOUT_CYCLES-1 in start, data or stop → release both lines, go to done with ack_err=1.
  - A missing device therefore ends the frame with an error instead of hanging.
- Undefined:
  - No watchdog; the block waits indefinitely for device clock edges and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package ps2_pkg:
  - state encodings: idle, rts, start, data, stop, done
  - FILTER_LEN default
  - frame constants: data bits = 8, shift count = 9
- Sub-module ps2_clk_filter (filter register + fall_edge), reusable by the receive path.

Test Plan:
- din=8'hED, device model clocks at ~12.5 kHz and ACKs low → clock held low 12000 cycles; start=0; data bits 1,0,1,1,0,1,1,1; parity=1; data released; tx_done_tick after edge 11; ack_err=0.
- din=8'h01 → parity bit=0; din=8'h00 → parity bit=1; verify ps2d_out sampled at each device rising edge.
- Device leaves data high at edge 11 → tx_done_tick with ack_err=1; tx_idle returns to 1 the next cycle.
- Second wr_ps2 issued during data state with din=8'h55 → ignored; frame still carries the original byte; exactly one tx_done_tick.
- reset driven low at data bit 4 → tri_c=tri_d=0 immediately; after release state=idle, tx_idle=1, no tx_done_tick.
- 2-cycle glitch on ps2c_in during data (PS2_TX_TIMEOUT_EN defined, device then stops clocking) → glitch causes no shift; after TIMEOUT_CYCLES, tx_done_tick with ack_err=1 and lines released.
